// File: rtl/seqdec_param.sv
// rtl/seqdec_param.sv - parametrised serial sequence detector with match counter
//
// Detects a LEN-bit pattern (MSB = oldest bit) on a qualified serial stream.
// The pattern is runtime-loadable, detection is overlapping (Mode=0) or
// non-overlapping (Mode=1), and matches are counted in a saturating counter.
//
// Optional feature macro: SEQDEC_MASK_EN adds Mask_in and a mask register;
// a mask bit of 1 makes that pattern position don't-care.
//
// Ports:
//   Clk      in   1      clock, rising edge
//   Reset    in   1      synchronous, active-high reset
//   Inp      in   1      serial data bit
//   In_vld   in   1      Inp qualifier
//   Pat_ld   in   1      load pattern from Pat_in (clears history and fill)
//   Pat_in   in   LEN    new pattern, MSB = first bit in time
//   Mode     in   1      0 = overlapping, 1 = non-overlapping
//   Cnt_clr  in   1      clear match counter
//   Mask_in  in   LEN    don't-care mask, loaded on Pat_ld (SEQDEC_MASK_EN only)
//   Out      out  1      one-cycle registered match pulse
//   Cnt      out  CNT_W  saturating match count
//   Cnt_sat  out  1      high while Cnt is all-ones

module seqdec_param #(
  parameter int               LEN     = 8,
  parameter logic [LEN-1:0]   PATTERN = 8'b01010010,
  parameter int               CNT_W   = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Inp,
  input  logic             In_vld,
  input  logic             Pat_ld,
  input  logic [LEN-1:0]   Pat_in,
  input  logic             Mode,
  input  logic             Cnt_clr,
`ifdef SEQDEC_MASK_EN
  input  logic [LEN-1:0]   Mask_in,
`endif
  output logic             Out,
  output logic [CNT_W-1:0] Cnt,
  output logic             Cnt_sat
);

  localparam int              FW        = $clog2(LEN + 1);
  localparam logic [FW-1:0]   FILL_FULL = FW'(LEN);
  localparam logic [FW-1:0]   FILL_LAST = FW'(LEN - 1);

  logic [LEN-1:0] hist;
  logic [LEN-1:0] pattern;
  logic [LEN-1:0] window;
  logic [LEN-1:0] care;
  logic [FW-1:0]  fill;
  logic           match;

`ifdef SEQDEC_MASK_EN
  logic [LEN-1:0] mask;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mask <= '0;
    end else if (Pat_ld) begin
      mask <= Mask_in;
    end
  end

  assign care = ~mask;
`else
  assign care = '1;
`endif

  // Window as it will look once the current bit is shifted in; the match is
  // decided on that edge so Out can be registered with one cycle of latency.
  assign window = {hist[LEN-2:0], Inp};

  // fill >= LEN-1 means the current bit completes LEN fresh bits, so the
  // zeroed history after reset/load can never produce a false match.
  // A load on the same edge discards Inp, hence no match either.
  assign match = In_vld && !Pat_ld && (fill >= FILL_LAST) &&
                 (((window ^ pattern) & care) == '0);

  assign Cnt_sat = &Cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hist    <= '0;
      fill    <= '0;
      pattern <= PATTERN;
      Out     <= 1'b0;
      Cnt     <= '0;
    end else begin
      if (Pat_ld) begin
        pattern <= Pat_in;
        hist    <= '0;
        fill    <= '0;
        Out     <= 1'b0;
      end else if (In_vld) begin
        hist <= window;
        Out  <= match;
        if (match && Mode) begin
          fill <= '0;
        end else if (fill != FILL_FULL) begin
          fill <= fill + 1'b1;
        end
      end else begin
        Out <= 1'b0;
      end

      // Clear then count: a match on the clearing edge leaves Cnt at 1.
      if (Cnt_clr) begin
        Cnt <= CNT_W'(match);
      end else if (match && !Cnt_sat) begin
        Cnt <= Cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seqdec_param.sv
// tb/tb_seqdec_param.sv - self-checking bench for seqdec_param

module tb_seqdec_param;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, Inp, In_vld, Pat_ld, Mode, Cnt_clr;
  logic [7:0] pat8;
  logic [3:0] pat4;
`ifdef SEQDEC_MASK_EN
  logic [7:0] mask8;
  logic [3:0] mask4;
`endif

  logic       d8_out, d4_out, dc_out;
  logic [7:0] d8_cnt, d4_cnt;
  logic [1:0] dc_cnt;
  logic       d8_sat, d4_sat, dc_sat;

  seqdec_param #(.LEN(8), .PATTERN(8'b01010010), .CNT_W(8)) d8 (
    .Clk(Clk), .Reset(Reset), .Inp(Inp), .In_vld(In_vld), .Pat_ld(Pat_ld),
    .Pat_in(pat8), .Mode(Mode), .Cnt_clr(Cnt_clr),
`ifdef SEQDEC_MASK_EN
    .Mask_in(mask8),
`endif
    .Out(d8_out), .Cnt(d8_cnt), .Cnt_sat(d8_sat));

  seqdec_param #(.LEN(4), .PATTERN(4'b0011), .CNT_W(8)) d4 (
    .Clk(Clk), .Reset(Reset), .Inp(Inp), .In_vld(In_vld), .Pat_ld(Pat_ld),
    .Pat_in(pat4), .Mode(Mode), .Cnt_clr(Cnt_clr),
`ifdef SEQDEC_MASK_EN
    .Mask_in(mask4),
`endif
    .Out(d4_out), .Cnt(d4_cnt), .Cnt_sat(d4_sat));

  seqdec_param #(.LEN(4), .PATTERN(4'b0011), .CNT_W(2)) dc (
    .Clk(Clk), .Reset(Reset), .Inp(Inp), .In_vld(In_vld), .Pat_ld(Pat_ld),
    .Pat_in(pat4), .Mode(Mode), .Cnt_clr(Cnt_clr),
`ifdef SEQDEC_MASK_EN
    .Mask_in(mask4),
`endif
    .Out(dc_out), .Cnt(dc_cnt), .Cnt_sat(dc_sat));

  int n_assert = 0;
  int n_fail   = 0;

  // Model: record every valid bit; a match is the last LEN bits recorded since
  // the latest restart point (reset, load, non-overlapping match) equalling
  // the pattern, oldest bit first.
  int          mlen[3] = '{8, 4, 4};
  int          mmax[3] = '{255, 255, 3};
  logic [31:0] mrst[3] = '{32'h52, 32'h3, 32'h3};
  logic [31:0] mpat[3];
  logic [31:0] mmask[3];
  int          mpos[3];
  int          mstart[3];
  int          mcnt[3];
  bit          mout[3];
  bit          strm[3][4096];

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit m;
      m = 1'b0;
      if (Reset) begin
        mstart[i] = mpos[i];
        mpat[i]   = mrst[i];
        mmask[i]  = 32'h0;
        mout[i]   = 1'b0;
        mcnt[i]   = 0;
      end else begin
        if (Pat_ld) begin
          mpat[i] = (i == 0) ? {24'h0, pat8} : {28'h0, pat4};
`ifdef SEQDEC_MASK_EN
          mmask[i] = (i == 0) ? {24'h0, mask8} : {28'h0, mask4};
`endif
          mstart[i] = mpos[i];
          mout[i]   = 1'b0;
        end else if (In_vld) begin
          strm[i][mpos[i]] = Inp;
          mpos[i]++;
          if (mpos[i] - mstart[i] >= mlen[i]) begin
            m = 1'b1;
            for (int k = 0; k < mlen[i]; k++)
              if (!mmask[i][mlen[i]-1-k] &&
                  strm[i][mpos[i]-mlen[i]+k] != mpat[i][mlen[i]-1-k])
                m = 1'b0;
          end
          if (m && Mode) mstart[i] = mpos[i];
          mout[i] = m;
        end else begin
          mout[i] = 1'b0;
        end
        if (Cnt_clr) mcnt[i] = m ? 1 : 0;
        else if (m && mcnt[i] < mmax[i]) mcnt[i]++;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("d8_out", int'(d8_out), int'(mout[0]));
    check("d8_cnt", int'(d8_cnt), mcnt[0]);
    check("d8_sat", int'(d8_sat), int'(mcnt[0] == mmax[0]));
    check("d4_out", int'(d4_out), int'(mout[1]));
    check("d4_cnt", int'(d4_cnt), mcnt[1]);
    check("d4_sat", int'(d4_sat), int'(mcnt[1] == mmax[1]));
    check("dc_out", int'(dc_out), int'(mout[2]));
    check("dc_cnt", int'(dc_cnt), mcnt[2]);
    check("dc_sat", int'(dc_sat), int'(mcnt[2] == mmax[2]));
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling
  // edge after the rising edge that sampled them.
  task automatic cyc(input bit rst, input bit ld, input bit vld, input bit b, input bit clr);
    Reset = rst; Pat_ld = ld; In_vld = vld; Inp = b; Cnt_clr = clr;
    model_step();
    @(posedge Clk);
    @(negedge Clk);
    compare_all();
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int j = n - 1; j >= 0; j--) cyc(1'b0, 1'b0, 1'b1, bits[j], 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int          sat_exp[4] = '{2, 3, 3, 3};
  int          sat_flag[4] = '{0, 1, 1, 1};
  logic [63:0] mix = 64'hA5D2_9352_5294_A50F;

  initial begin
    Reset = 1'b1; Inp = 1'b0; In_vld = 1'b0; Pat_ld = 1'b0; Mode = 1'b0; Cnt_clr = 1'b0;
    pat8 = 8'b01010010; pat4 = 4'b1010;
`ifdef SEQDEC_MASK_EN
    mask8 = 8'h00; mask4 = 4'h0;
`endif

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_out", int'(d8_out), 0);
    check("rst_cnt", int'(d8_cnt), 0);
    check("rst_sat", int'(d8_sat), 0);
    check("rst_dc_cnt", int'(dc_cnt), 0);

    // Default pattern, one clean pass
    send(32'b0101001, 7);
    check("t1_pre", int'(d8_out), 0);
    cyc(0, 0, 1, 0, 0);
    check("t1_out", int'(d8_out), 1);
    check("t1_cnt", int'(d8_cnt), 1);
    idle();
    check("t1_pulse_end", int'(d8_out), 0);

    // LEN=4, overlapping
    cyc(0, 1, 0, 0, 1);
    send(32'b1010, 4);
    check("t2_ov_m1", int'(d4_out), 1);
    cyc(0, 0, 1, 1, 0);
    check("t2_ov_gap", int'(d4_out), 0);
    cyc(0, 0, 1, 0, 0);
    check("t2_ov_m2", int'(d4_out), 1);
    check("t2_ov_cnt", int'(d4_cnt), 2);

    // LEN=4, non-overlapping
    Mode = 1'b1;
    cyc(0, 1, 0, 0, 1);
    send(32'b1010, 4);
    check("t2_no_m1", int'(d4_out), 1);
    send(32'b10, 2);
    check("t2_no_m2", int'(d4_out), 0);
    check("t2_no_cnt", int'(d4_cnt), 1);
    Mode = 1'b0;

    // Idle gap between bits 4 and 5
    cyc(0, 1, 0, 0, 1);
    send(32'b0101, 4);
    for (int r = 0; r < 3; r++) begin
      idle();
      check("t3_idle", int'(d8_out), 0);
    end
    send(32'b001, 3);
    check("t3_pre", int'(d8_out), 0);
    cyc(0, 0, 1, 0, 0);
    check("t3_out", int'(d8_out), 1);
    check("t3_cnt", int'(d8_cnt), 1);

    // Reset mid-sequence: a stale prefix would otherwise complete early
    send(32'b01010, 5);
    cyc(1, 0, 0, 0, 0);
    send(32'b010, 3);
    check("t4_no_stale", int'(d8_out), 0);
    send(32'b1001, 4);
    check("t4_pre_cnt", int'(d8_cnt), 0);
    cyc(0, 0, 1, 0, 0);
    check("t4_out", int'(d8_out), 1);
    check("t4_cnt", int'(d8_cnt), 1);

    // Bit offered with Pat_ld is discarded
    cyc(0, 1, 1, 0, 1);
    send(32'b1010010, 7);
    check("t4_ld_discard", int'(d8_cnt), 0);
    send(32'h52, 8);
    check("t4_ld_out", int'(d8_out), 1);
    check("t4_ld_cnt", int'(d8_cnt), 1);

    // CNT_W=2 saturation, then clear on a match edge
    cyc(0, 1, 0, 0, 1);
    send(32'b1010, 4);
    check("t5_cnt0", int'(dc_cnt), 1);
    for (int r = 0; r < 4; r++) begin
      send(32'b10, 2);
      check("t5_cnt", int'(dc_cnt), sat_exp[r]);
      check("t5_sat", int'(dc_sat), sat_flag[r]);
    end
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 0, 1);
    check("t5_clr_out", int'(dc_out), 1);
    check("t5_clr_cnt", int'(dc_cnt), 1);
    check("t5_clr_sat", int'(dc_sat), 0);

    // Mixed stream with gaps and a mode flip, checked by the model only
    cyc(0, 1, 0, 0, 1);
    for (int j = 63; j >= 0; j--) begin
      Mode = (j < 32);
      cyc(0, 0, (j % 5) != 0, mix[j], 0);
    end
    Mode = 1'b0;

`ifdef SEQDEC_MASK_EN
    mask8 = 8'b00000011;
    cyc(0, 1, 0, 0, 1);
    send(32'b01010000, 8);
    check("t6_mask_00", int'(d8_out), 1);
    cyc(0, 1, 0, 0, 0);
    send(32'b01010011, 8);
    check("t6_mask_11", int'(d8_out), 1);
    check("t6_mask_cnt", int'(d8_cnt), 2);
`endif

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seqdec_param.md
Name: seqdec_param

Overview:
- Parametrised serial sequence detector; successor to the fixed 8-bit hardwired-pattern detector.
- Adds runtime-loadable pattern, overlapping/non-overlapping modes, input qualifier and a saturating match counter.
- Sits on a 1-bit serial input stream in the HW test harness; drives a match pulse and a count.

Parameters:
LEN, 8, pattern length in bits (2..32); pattern MSB = oldest bit in time.
PATTERN, 8'b01010010, reset value of the pattern register (LEN bits).
CNT_W, 8, width of the match counter.

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
Inp  input  1  serial data bit
In_vld  input  1  Inp is sampled only when high
Pat_ld  input  1  load new pattern from Pat_in
Pat_in  input  LEN  new pattern, MSB = first bit in time
Mode  input  1  0 = overlapping detection, 1 = non-overlapping
Cnt_clr  input  1  clear match counter
Out  output  1  one-cycle match pulse
Cnt  output  CNT_W  number of matches since reset/clear, saturating
Cnt_sat  output  1  high while Cnt is at all-ones

Behaviour:
- Interface: one clock, Clk; Reset is synchronous and active-high. All flops clear on the Clk edge where Reset=1. Reset has priority over every other input.
- Reset values: history=0, fill=0, pattern=PATTERN, Out=0, Cnt=0, Cnt_sat=0.
- History: LEN-bit shift register. On an edge with In_vld=1, hist <= {hist[LEN-2:0], Inp}. With In_vld=0, history holds and Out <= 0.
- Fill counter: counts valid bits and saturates at LEN. No match is possible until LEN valid bits have been received since the last reset, pattern load or non-overlapping match. This prevents false matches on the zeroed history.
- Match condition: In_vld=1, fill>=LEN-1 and {hist[LEN-2:0],Inp}==pattern.
- Latency: Out is registered. It is high for exactly the one cycle following the edge that sampled the completing bit. Back-to-back matches give Out high on consecutive cycles.
- Mode=0 (overlapping): fill is unaffected by a match. E.g. LEN=4, pattern 1010, stream 1010 10 gives two matches.
- Mode=1 (non-overlapping): on a match edge, fill <= 0. History still shifts. The next match needs LEN fresh bits. Same stream gives one match.
- Mode is sampled every edge. A change takes effect from the next match decision and does not clear any state.
- Pat_ld: pattern <= Pat_in, history <= 0, fill <= 0, Out <= 0.
  - Pat_ld has priority over In_vld: a simultaneous Inp is discarded.
  - Cnt is not affected by Pat_ld.
- Counter: on a match edge Cnt <= Cnt+1 unless all-ones, in which case it holds. Cnt_sat = &Cnt (combinational from the register).
- Cnt_clr: Cnt <= 0. If a match occurs on the same edge, Cnt <= 1 (clear then count). Out is unaffected.
- Reset mid-sequence: partial match is lost; detection restarts from fill=0 with pattern=PATTERN.

Optional Feature:
- Macro SEQDEC_MASK_EN.
- Defined: adds port Mask_in (input, LEN), loaded into a mask register on Pat_ld; the mask resets to all-zeros. A mask bit of 1 makes that pattern position don't-care. Match compares ({hist[LEN-2:0],Inp} ^ pattern) & ~mask == 0. All other rules are unchanged.
- Not defined: no Mask_in port and no mask register; exact match on all LEN bits.

Test Plan:
- Reset, default params, stream 0,1,0,1,0,0,1,0 with In_vld=1 each cycle -> Out=1 only in the cycle after the 8th bit; Cnt=1.
- Pat_ld with LEN=4 instance, Pat_in=4'b1010, Mode=0, stream 1,0,1,0,1,0 -> Out pulses after bits 4 and 6; Cnt=2. Same with Mode=1 -> single pulse after bit 4; Cnt=1.
- Default pattern, In_vld toggled low for 3 cycles between bits 4 and 5 -> still exactly one match. Out=0 during the idle cycles.
- Reset asserted after 5 matching bits, then 8 matching bits -> exactly one match, after the final 8 bits. Also: Pat_ld asserted with In_vld=1 -> that Inp is ignored (verified by an off-by-one stream).
- CNT_W=2, 5 overlapping matches -> Cnt 1,2,3,3,3; Cnt_sat high from the 3rd match. Cnt_clr on the same edge as a match -> Cnt=1.
- SEQDEC_MASK_EN defined, Pat_in=8'b01010010, Mask_in=8'b00000011 -> streams ending ...00 and ...11 in the last two bits both match.
